// File: rtl/fetch_unit.sv
// Instruction-fetch stage with F/D pipeline register.
// Owns pc_F, redirects on Decode branches/jumps (predict taken) and recovers
// the fall-through PC from a small FIFO when Execute reports a misprediction.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned FT_DEPTH  = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        branch_D,
    input  logic        jump_D,
    input  logic [31:0] target_D,
    input  logic        branch_E,
    input  logic        condition_met_E,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc_plus4_D,
    output logic        valid_D,
    output logic        ft_overflow
);

    localparam int unsigned PTR_W = (FT_DEPTH > 1) ? $clog2(FT_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FT_DEPTH);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, pc_d_q, pc4_d_q;
    logic        valid_q;

    logic [31:0]      ft_mem_q [FT_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic        resolve, mispredict, push;
    logic        ft_empty, ft_full, do_pop, do_push;
    logic [31:0] ft_head;

    // Branch bookkeeping only advances when Execute is actually moving.
    assign resolve    = branch_E && !StallF;
    assign mispredict = resolve && !condition_met_E;
    assign push       = branch_D && !StallD && !mispredict;

    assign ft_empty = (count_q == '0);
    assign ft_full  = (count_q == FULL_CNT);
    // On an empty pop this is deliberately the stale entry at head.
    assign ft_head  = ft_mem_q[head_q];

    assign imem_addr   = pc_q;
    assign instr_D     = instr_q;
    assign pc_D        = pc_d_q;
    assign pc_plus4_D  = pc4_d_q;
    assign valid_D     = valid_q;
    assign ft_overflow = ovf_q;

    // Next fetch PC: stall, recover, redirect, sequential.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (StallF) begin
            pc_d = pc_q;
        end else if (mispredict) begin
            pc_d = ft_head;
        end else if (branch_D || jump_D) begin
            pc_d = target_D;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // F/D pipeline register; flush beats stall.
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            instr_q <= NOP_INSTR;
            pc_d_q  <= 32'd0;
            pc4_d_q <= 32'd0;
            valid_q <= 1'b0;
        end else if (!StallD) begin
            instr_q <= imem_rdata;
            pc_d_q  <= pc_q;
            pc4_d_q <= pc_q + 32'd4;
            valid_q <= 1'b1;
        end
    end

    // Fall-through FIFO next state; a mispredict squashes every younger entry.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        do_pop  = 1'b0;
        do_push = 1'b0;
        if (mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (ft_empty) begin
                ovf_d = 1'b1;
            end
        end else begin
            do_pop  = resolve && !ft_empty;
            do_push = push && (!ft_full || do_pop);
            if ((resolve && ft_empty) || (push && ft_full && !do_pop)) begin
                ovf_d = 1'b1;
            end
            if (do_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (do_push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO pointers, count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage; the pushed value is the fall-through of the branch in Decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FT_DEPTH; i++) begin
                ft_mem_q[i] <= 32'd0;
            end
        end else if (do_push) begin
            ft_mem_q[tail_q] <= pc4_d_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus process runs a queue-based
// reference model and pushes expectations; a monitor compares after each edge.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, branch_D, jump_D;
    logic [31:0] target_D;
    logic        branch_E, condition_met_E;
    logic [31:0] imem_rdata, imem_addr, instr_D, pc_D, pc_plus4_D;
    logic        valid_D, ft_overflow;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .FT_DEPTH (DEPTH),
        .NOP_INSTR(NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .StallF         (StallF),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .branch_D       (branch_D),
        .jump_D         (jump_D),
        .target_D       (target_D),
        .branch_E       (branch_E),
        .condition_met_E(condition_met_E),
        .imem_rdata     (imem_rdata),
        .imem_addr      (imem_addr),
        .instr_D        (instr_D),
        .pc_D           (pc_D),
        .pc_plus4_D     (pc_plus4_D),
        .valid_D        (valid_D),
        .ft_overflow    (ft_overflow)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pc4;
        logic        valid;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   armed = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
    logic        m_valid, m_ovf;
    logic [31:0] m_ftq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per clock edge once stimulus has started.
    always @(posedge clk) begin
        #1;
        if (armed) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard: no expectation queued at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("imem_addr", imem_addr, e.pc);
                chk("instr_D", instr_D, e.instr);
                chk("pc_D", pc_D, e.pcd);
                chk("pc_plus4_D", pc_plus4_D, e.pc4);
                chk("valid_D", {31'd0, valid_D}, {31'd0, e.valid});
                chk("ft_overflow", {31'd0, ft_overflow}, {31'd0, e.ovf});
            end
        end
    end

    // Drive one cycle of inputs and advance the reference model across that edge.
    task automatic step(input logic rst, input logic sf, input logic sd, input logic fd,
                        input logic bd, input logic jd, input logic [31:0] tgt,
                        input logic be, input logic cme);
        logic        res, misp;
        logic [31:0] n_pc;
        exp_t        e;
        @(negedge clk);
        reset = rst; StallF = sf; StallD = sd; FlushD = fd;
        branch_D = bd; jump_D = jd; target_D = tgt;
        branch_E = be; condition_met_E = cme;
        armed = 1;
        res  = be && !sf;
        misp = res && !cme;
        if (rst) begin
            m_pc = 32'd0; m_instr = NOP; m_pcd = 32'd0; m_pc4 = 32'd0;
            m_valid = 1'b0; m_ovf = 1'b0;
            m_ftq.delete();
        end else begin
            if (sf) n_pc = m_pc;
            else if (misp) n_pc = m_ftq[0];
            else if (bd || jd) n_pc = tgt;
            else n_pc = m_pc + 32'd4;
            if (misp) begin
                m_ftq.delete();
            end else begin
                if (res) begin
                    if (m_ftq.size() > 0) void'(m_ftq.pop_front());
                    else m_ovf = 1'b1;
                end
                if (bd && !sd) begin
                    if (m_ftq.size() < DEPTH) m_ftq.push_back(m_pc4);
                    else m_ovf = 1'b1;
                end
            end
            if (fd) begin
                m_instr = NOP; m_pcd = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
            end else if (!sd) begin
                m_instr = mem_word(m_pc); m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            end
            m_pc = n_pc;
        end
        e.pc = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.pc4 = m_pc4;
        e.valid = m_valid; e.ovf = m_ovf;
        exp_q.push_back(e);
    endtask

    task automatic plain();
        step(0, 0, 0, 0, 0, 0, 32'd0, 0, 0);
    endtask

    // Reset, fetch up to pc_D=0x10, then take branch to 0x40 with a flush.
    task automatic prefix();
        step(1, 0, 0, 0, 0, 0, 32'd0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 32'd0, 0, 0);
        repeat (5) plain();
        step(0, 0, 0, 1, 1, 0, 32'h40, 0, 0);
    endtask

    // Sample after the monitor has consumed the last edge.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1; StallF = 0; StallD = 0; FlushD = 0; branch_D = 0; jump_D = 0;
        target_D = 0; branch_E = 0; condition_met_E = 0;

        // Mispredict recovery.
        prefix();
        settle();
        chk("redirect_pc", imem_addr, 32'h40);
        chk("flush_instr", instr_D, NOP);
        plain();
        step(0, 0, 0, 0, 0, 0, 32'd0, 1, 0);
        settle();
        chk("mispredict_pc", imem_addr, 32'h14);

        // Correct prediction keeps streaming.
        prefix();
        plain();
        step(0, 0, 0, 0, 0, 0, 32'd0, 1, 1);
        settle();
        chk("correct_pc", imem_addr, 32'h48);

        // Stalled resolution waits for the first unstalled edge.
        prefix();
        plain();
        step(0, 1, 1, 0, 0, 0, 32'd0, 1, 0);
        step(0, 1, 1, 0, 0, 0, 32'd0, 1, 0);
        settle();
        chk("stall_hold_pc", imem_addr, 32'h44);
        step(0, 0, 0, 0, 0, 0, 32'd0, 1, 0);
        settle();
        chk("stall_misp_pc", imem_addr, 32'h14);

        // Back-to-back branches: push and correct pop overlap.
        prefix();
        plain();
        step(0, 0, 0, 1, 1, 0, 32'h80, 1, 1);
        plain();
        step(0, 0, 0, 0, 0, 0, 32'd0, 1, 0);
        settle();
        chk("b2b_pc", imem_addr, 32'h44);

        // Overflow on third push, then reset mid-stream.
        prefix();
        step(0, 0, 0, 0, 1, 0, 32'h100, 0, 0);
        step(0, 0, 0, 0, 1, 0, 32'h200, 0, 0);
        plain();
        settle();
        chk("overflow_set", {31'd0, ft_overflow}, 32'd1);
        step(1, 0, 0, 0, 1, 0, 32'h300, 1, 0);
        settle();
        chk("reset_pc", imem_addr, 32'd0);
        chk("reset_ovf", {31'd0, ft_overflow}, 32'd0);

        // PC wrap-around.
        step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        plain();
        settle();
        chk("wrap_pc", imem_addr, 32'd0);

        // Random phase.
        for (int i = 0; i < 4000; i++) begin
            logic rst, sf, sd, fd, bd, jd, be, cme;
            logic [31:0] tgt;
            rst = ($urandom_range(0, 99) == 0);
            sf  = ($urandom_range(0, 4) == 0);
            sd  = ($urandom_range(0, 4) == 0) || (sf && $urandom_range(0, 1) == 1);
            fd  = ($urandom_range(0, 5) == 0);
            bd  = ($urandom_range(0, 3) == 0);
            jd  = ($urandom_range(0, 7) == 0);
            be  = ($urandom_range(0, 2) == 0);
            cme = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 9))
                0:       tgt = 32'hFFFF_FFFC;
                1:       tgt = $urandom;
                default: tgt = {$urandom_range(0, 32'h3FFF), 2'b00};
            endcase
            // The stale-head case is exercised only through correct pops.
            if (!rst && be && !sf && !cme && m_ftq.size() == 0) cme = 1'b1;
            step(rst, sf, sd, fd, bd, jd, tgt, be, cme);
        end
        settle();
        armed = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
